sram_stream_reader: RTL and testbench

SRAM_STREAM_READER -- requirements
Module: sram_stream_reader

---
 rtl/sram_stream_reader_if.sv | 30 +++
 rtl/sram_stream_reader.sv | 120 ++++++++++++
 tb/tb_sram_stream_reader.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_stream_reader_if.sv
// Control, SRAM-bus client and stream-out signals of one sram_stream_reader instance.
// master is the reader itself; slave is the controller/bus/consumer side.
interface sram_stream_reader_if #(
    parameter int ADDRESS_BUS_WIDTH = 16,
    parameter int DATA_BUS_WIDTH    = 16,
    parameter int COUNT_WIDTH       = 16
);
    logic                         start;
    logic [ADDRESS_BUS_WIDTH-1:0] base_address;
    logic [COUNT_WIDTH-1:0]       word_count;
    logic                         busy;
    logic                         done_strobe;
    logic                         read_request;
    logic [ADDRESS_BUS_WIDTH-1:0] read_address;
    logic                         read_finished_strobe;
    logic [DATA_BUS_WIDTH-1:0]    read_data;
    logic [DATA_BUS_WIDTH-1:0]    data_out;
    logic                         data_valid;
    logic                         data_pop;

    modport master (
        input  start, base_address, word_count, read_finished_strobe, read_data, data_pop,
        output busy, done_strobe, read_request, read_address, data_out, data_valid
    );

    modport slave (
        output start, base_address, word_count, read_finished_strobe, read_data, data_pop,
        input  busy, done_strobe, read_request, read_address, data_out, data_valid
    );
endinterface

// File: rtl/sram_stream_reader.sv
// Fetches word_count consecutive SRAM words, one request at a time, into a prefetch FIFO
// that a consumer drains with data_pop.
module sram_stream_reader #(
    parameter int ADDRESS_BUS_WIDTH = 16,
    parameter int DATA_BUS_WIDTH    = 16,
    parameter int FIFO_DEPTH        = 4,
    parameter int COUNT_WIDTH       = 16
) (
    input logic                   clk,
    input logic                   rst,
    sram_stream_reader_if.master  bus
);
    localparam int PtrW = $clog2(FIFO_DEPTH);
    localparam int OccW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StFetch, StFinish} state_e;

    state_e                       state_q, state_d;
    logic [ADDRESS_BUS_WIDTH-1:0] addr_q, addr_d;
    logic [COUNT_WIDTH-1:0]       remain_q, remain_d;
    logic                         req_q, req_d;
    logic                         done_q;

    logic [DATA_BUS_WIDTH-1:0]    mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]              wr_ptr_q, rd_ptr_q;
    logic [OccW-1:0]              occ_q;

    logic push, pop, room, complete;

    assign pop      = bus.data_pop && (occ_q != '0);
    // A pop in the same cycle frees a slot before the requested word can arrive.
    assign room     = (occ_q != OccW'(FIFO_DEPTH)) || pop;
    assign complete = req_q && bus.read_finished_strobe;
    assign push     = complete;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        req_d    = req_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (bus.word_count == '0) begin
                        state_d = StFinish;
                    end else begin
                        state_d  = StFetch;
                        addr_d   = bus.base_address;
                        remain_d = bus.word_count;
                        req_d    = room;
                    end
                end
            end
            StFetch: begin
                if (complete) begin
                    req_d    = 1'b0;
                    addr_d   = addr_q + ADDRESS_BUS_WIDTH'(1);
                    remain_d = remain_q - COUNT_WIDTH'(1);
                    if (remain_q == COUNT_WIDTH'(1)) begin
                        state_d = StFinish;
                    end
                end else if (!req_q) begin
                    req_d = room;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            remain_q <= '0;
            req_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            req_q    <= req_d;
            done_q   <= (state_q == StFinish);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + OccW'(1);
                2'b01:   occ_q <= occ_q - OccW'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.read_data;
        end
    end

    assign bus.busy         = (state_q != StIdle);
    assign bus.done_strobe  = done_q;
    assign bus.read_request = req_q;
    assign bus.read_address = addr_q;
    assign bus.data_out     = mem_q[rd_ptr_q];
    assign bus.data_valid   = (occ_q != '0);
endmodule

// File: tb/tb_sram_stream_reader.sv
// Scoreboarded bench: request addresses and returned words are queued as expected values
// and compared when the reader issues requests and the consumer pops words.
module tb_sram_stream_reader;
    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int Depth = 4;
    localparam int CW    = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_stream_reader_if #(
        .ADDRESS_BUS_WIDTH(AW),
        .DATA_BUS_WIDTH   (DW),
        .COUNT_WIDTH      (CW)
    ) bus ();

    sram_stream_reader #(
        .ADDRESS_BUS_WIDTH(AW),
        .DATA_BUS_WIDTH   (DW),
        .FIFO_DEPTH       (Depth),
        .COUNT_WIDTH      (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [AW-1:0] exp_addr[$];
    logic [DW-1:0] exp_data[$];

    int lat          = 0;
    bit pop_en       = 1'b0;
    int pop_budget   = 0;
    bit stray_req    = 1'b0;
    int req_total    = 0;
    int strobe_total = 0;
    int done_total   = 0;
    int pop_total    = 0;
    int r0, p0, d0, s0, n;

    function automatic logic [DW-1:0] mem_model(logic [AW-1:0] a);
        return a ^ 16'h5A3C;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(logic [AW-1:0] base, logic [CW-1:0] cnt);
        bus.start        = 1'b1;
        bus.base_address = base;
        bus.word_count   = cnt;
        for (int i = 0; i < int'(cnt); i++) exp_addr.push_back(base + AW'(i));
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(string tag, int max_cycles);
        int d_start;
        int k;
        d_start = done_total;
        k = 0;
        while (done_total == d_start && k < max_cycles) begin
            tick();
            k++;
        end
        check(tag, 32'(done_total > d_start), 1);
    endtask

    // SRAM bus model: answers each request after lat cycles.
    initial begin
        int            wait_cnt;
        bit            seen;
        bit            drop_chk;
        logic [AW-1:0] exp_cur;
        bus.read_finished_strobe = 1'b0;
        bus.read_data            = '0;
        wait_cnt = 0;
        seen     = 1'b0;
        drop_chk = 1'b0;
        exp_cur  = '0;
        forever begin
            @(negedge clk);
            if (drop_chk) begin
                check("req_drop", 32'(bus.read_request), 0);
                drop_chk = 1'b0;
            end
            if (rst) begin
                bus.read_finished_strobe = 1'b0;
                seen = 1'b0;
            end else if (bus.read_finished_strobe) begin
                bus.read_finished_strobe = 1'b0;
            end else if (stray_req) begin
                bus.read_finished_strobe = 1'b1;
                bus.read_data            = 16'hDEAD;
                stray_req                = 1'b0;
            end else if (bus.read_request) begin
                if (!seen) begin
                    seen     = 1'b1;
                    wait_cnt = 0;
                    req_total++;
                    if (exp_addr.size() > 0) begin
                        exp_cur = exp_addr.pop_front();
                        check("req_addr", 32'(bus.read_address), 32'(exp_cur));
                    end else begin
                        check("req_extra", 1, 0);
                    end
                end else begin
                    check("req_hold", 32'(bus.read_address), 32'(exp_cur));
                end
                if (wait_cnt >= lat) begin
                    bus.read_finished_strobe = 1'b1;
                    bus.read_data            = mem_model(exp_cur);
                    exp_data.push_back(mem_model(exp_cur));
                    strobe_total++;
                    seen     = 1'b0;
                    drop_chk = 1'b1;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // Consumer: pops continuously under pop_en, or pop_budget single words.
    initial begin
        bus.data_pop = 1'b0;
        forever begin
            @(negedge clk);
            bus.data_pop = 1'b0;
            if (!rst && bus.data_valid && (pop_en || pop_budget > 0)) begin
                if (exp_data.size() > 0) check("pop_data", 32'(bus.data_out),
                                               32'(exp_data.pop_front()));
                else check("pop_extra", 1, 0);
                bus.data_pop = 1'b1;
                pop_total++;
                if (pop_budget > 0) pop_budget--;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus.done_strobe) begin
                done_total++;
                check("done_busy_low", 32'(bus.busy), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.base_address = '0;
        bus.word_count   = '0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done_strobe), 0);
        check("rst_req", 32'(bus.read_request), 0);
        check("rst_valid", 32'(bus.data_valid), 0);
        check("rst_addr", 32'(bus.read_address), 0);
        tick();
        rst = 1'b0;
        tick();

        // Basic 3-word transfer, strobe 2 cycles after request, consumer always popping.
        lat = 2; pop_en = 1'b1;
        r0 = req_total; p0 = pop_total; d0 = done_total;
        do_start(16'h0100, 3);
        @(negedge clk);
        check("t1_req_first_cycle", 32'(bus.read_request), 1);
        check("t1_busy", 32'(bus.busy), 1);
        wait_done("t1_done", 60);
        repeat (4) tick();
        check("t1_reqs", req_total - r0, 3);
        check("t1_pops", pop_total - p0, 3);
        check("t1_done_cnt", done_total - d0, 1);
        check("t1_busy_end", 32'(bus.busy), 0);

        // FIFO back-pressure: 6 words, no pops, only Depth requests issue.
        lat = 1; pop_en = 1'b0;
        r0 = req_total;
        do_start(16'h0200, 6);
        repeat (30) tick();
        check("t2_reqs_full", req_total - r0, Depth);
        check("t2_req_low", 32'(bus.read_request), 0);
        check("t2_valid", 32'(bus.data_valid), 1);
        pop_budget = 1;
        @(negedge clk);
        @(negedge clk);
        check("t2_req_after_pop", 32'(bus.read_request), 1);
        tick();
        pop_en = 1'b1;
        wait_done("t2_done", 100);
        repeat (4) tick();
        check("t2_reqs_total", req_total - r0, 6);
        check("t2_empty", 32'(bus.data_valid), 0);

        // Address wrap.
        lat = 0;
        do_start(16'hFFFE, 3);
        wait_done("t3_done", 60);
        repeat (4) tick();
        check("t3_addr_after_wrap", 32'(bus.read_address), 32'h0001);

        // Zero-length transfer.
        r0 = req_total; d0 = done_total;
        do_start(16'h1234, 0);
        @(negedge clk);
        check("t4_busy_n1", 32'(bus.busy), 1);
        check("t4_req_n1", 32'(bus.read_request), 0);
        check("t4_done_n1", 32'(bus.done_strobe), 0);
        tick();
        @(negedge clk);
        check("t4_busy_n2", 32'(bus.busy), 0);
        check("t4_done_n2", 32'(bus.done_strobe), 1);
        tick();
        @(negedge clk);
        check("t4_done_n3", 32'(bus.done_strobe), 0);
        check("t4_no_req", req_total - r0, 0);
        tick();

        // Push and pop in the same cycle with two words held.
        pop_en = 1'b0; lat = 0;
        p0 = pop_total; s0 = strobe_total;
        do_start(16'h0300, 3);
        n = 0;
        while (strobe_total < s0 + 2 && n < 50) begin
            tick();
            n++;
        end
        tick();
        pop_budget = 1;
        wait_done("t5_done", 60);
        repeat (3) tick();
        check("t5_valid_held", 32'(bus.data_valid), 1);
        pop_budget = 2;
        repeat (5) tick();
        check("t5_pops", pop_total - p0, 3);
        check("t5_empty", 32'(bus.data_valid), 0);

        // Reset while a request is outstanding, then a stray strobe.
        lat = 1000; pop_en = 1'b0;
        do_start(16'h0400, 2);
        @(negedge clk);
        check("t6_req_before_rst", 32'(bus.read_request), 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_addr.delete();
        exp_data.delete();
        @(negedge clk);
        check("t6_req_after_rst", 32'(bus.read_request), 0);
        check("t6_valid_after_rst", 32'(bus.data_valid), 0);
        check("t6_busy_after_rst", 32'(bus.busy), 0);
        check("t6_addr_after_rst", 32'(bus.read_address), 0);
        stray_req = 1'b1;
        repeat (4) tick();
        check("t6_stray_req", 32'(bus.read_request), 0);
        check("t6_stray_valid", 32'(bus.data_valid), 0);
        lat = 0; pop_en = 1'b1;
        p0 = pop_total;
        do_start(16'h0500, 1);
        wait_done("t6_done", 40);
        repeat (3) tick();
        check("t6_recover_pops", pop_total - p0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
